// File: rtl/sfifo_param.sv
// rtl/sfifo_param.sv - parametrised single-clock first-word-fall-through FIFO
// Registered status, occupancy count, almost flags, sync flush, sticky ovf/udf.
module sfifo_param #(
  parameter int AFIFODW   = 32,
  parameter int AFIFOAW   = 2,
  parameter int AFULL_TH  = 3,
  parameter int AEMPTY_TH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               wen,
  input  logic [AFIFODW-1:0] wdata,
  output logic               wqfull,
  output logic               walmost_full,
  input  logic               rnext,
  output logic [AFIFODW-1:0] rdata,
  output logic               rqempty,
  output logic               ralmost_empty,
  output logic [AFIFOAW:0]   count,
  output logic               ovf,
  output logic               udf,
  input  logic               err_clr
);

  localparam int                 PW       = AFIFOAW + 1;
  localparam int                 DEPTH    = 1 << AFIFOAW;
  localparam logic [AFIFOAW:0]   AFULL_C  = PW'(AFULL_TH);
  localparam logic [AFIFOAW:0]   AEMPTY_C = PW'(AEMPTY_TH);
  localparam logic               AF_RST   = (AFULL_TH == 0);

  logic [AFIFODW-1:0] mem_q [DEPTH];

  logic [AFIFOAW:0] wptr_q, wptr_d;
  logic [AFIFOAW:0] rptr_q, rptr_d;
  logic [AFIFOAW:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_ok, rd_ok;

  // Acceptance looks only at registered status, so no input reaches an output combinationally.
  assign wr_ok = wen & ~full_q & ~flush;
  assign rd_ok = rnext & ~empty_q & ~flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      if (rd_ok) rptr_d = rptr_q + 1'b1;
    end
    count_d  = wptr_d - rptr_d;
    empty_d  = (wptr_d == rptr_d);
    full_d   = (wptr_d[AFIFOAW] != rptr_d[AFIFOAW]) &&
               (wptr_d[AFIFOAW-1:0] == rptr_d[AFIFOAW-1:0]);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    // A fresh error in the same cycle as err_clr leaves the flag set.
    ovf_d = err_clr ? 1'b0 : ovf_q;
    udf_d = err_clr ? 1'b0 : udf_q;
    if (wen & full_q & ~flush)    ovf_d = 1'b1;
    if (rnext & empty_q & ~flush) udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= AF_RST;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[AFIFOAW-1:0]] <= wdata;
  end

  assign rdata         = mem_q[rptr_q[AFIFOAW-1:0]];
  assign wqfull        = full_q;
  assign rqempty       = empty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign count         = count_q;
  assign ovf           = ovf_q;
  assign udf           = udf_q;

endmodule

// File: tb/tb_sfifo_param.sv
// tb/tb_sfifo_param.sv - queue-model and directed checks for sfifo_param
// Model updates on posedge; one compare process checks every negedge.
module tb_sfifo_param;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AFT = 3;
  localparam int AET = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          wen = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          rnext = 1'b0;
  logic          err_clr = 1'b0;
  logic          wqfull, walmost_full, rqempty, ralmost_empty, ovf, udf;
  logic [DW-1:0] rdata;
  logic [AW:0]   count;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  logic [DW-1:0] mq[$];
  bit m_ovf, m_udf;

  sfifo_param #(.AFIFODW(DW), .AFIFOAW(AW), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wen(wen), .wdata(wdata),
    .wqfull(wqfull), .walmost_full(walmost_full), .rnext(rnext), .rdata(rdata),
    .rqempty(rqempty), .ralmost_empty(ralmost_empty), .count(count),
    .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a bounded queue plus two sticky bits.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf <= 1'b0;
      m_udf <= 1'b0;
    end else begin
      bit was_full, was_empty;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_ovf <= (err_clr ? 1'b0 : m_ovf) | (wen & was_full & ~flush);
      m_udf <= (err_clr ? 1'b0 : m_udf) | (rnext & was_empty & ~flush);
      if (flush) mq.delete();
      else begin
        if (rnext && !was_empty) void'(mq.pop_front());
        if (wen && !was_full) mq.push_back(wdata);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("count", 32'(count), 32'(mq.size()));
      check("rqempty", 32'(rqempty), 32'(mq.size() == 0));
      check("wqfull", 32'(wqfull), 32'(mq.size() == DEPTH));
      check("walmost_full", 32'(walmost_full), 32'(mq.size() >= AFT));
      check("ralmost_empty", 32'(ralmost_empty), 32'(mq.size() <= AET));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("udf", 32'(udf), 32'(m_udf));
      if (mq.size() > 0) check("rdata", 32'(rdata), 32'(mq[0]));
    end
  end

  task automatic drive(input bit w, input logic [DW-1:0] d, input bit r, input bit f, input bit ec);
    wen = w; wdata = d; rnext = r; flush = f; err_clr = ec;
    @(negedge clk);
    wen = 1'b0; rnext = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp4 [4];
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);

    check("rst_rqempty", 32'(rqempty), 32'd1);
    check("rst_wqfull", 32'(wqfull), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ralmost_empty", 32'(ralmost_empty), 32'd1);
    check("rst_walmost_full", 32'(walmost_full), 32'd0);
    check("rst_ovf_udf", 32'({ovf, udf}), 32'd0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, DW'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0);
      check("fill_count", 32'(count), 32'(i + 1));
      if (i == 2) check("afull_at3", 32'(walmost_full), 32'd1);
    end
    check("full_after4", 32'(wqfull), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("drain_rdata", 32'(rdata), 32'(8'h11 * (i + 1)));
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    check("empty_after_drain", 32'(rqempty), 32'd1);

    for (int i = 0; i < 4; i++) drive(1'b1, DW'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    check("full_both_count", 32'(count), 32'd3);
    check("full_both_ovf", 32'(ovf), 32'd1);
    drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
    check("refill_count", 32'(count), 32'd4);
    exp4 = '{8'h22, 8'h33, 8'h44, 8'h66};
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain", 32'(rdata), 32'(exp4[i]));
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end

    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      check("wrap_count", 32'(count), 32'd1);
      check("wrap_rdata", 32'(rdata), 32'(i - 1));
      drive(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    end
    check("wrap_last", 32'(rdata), 32'h09);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("wrap_errs", 32'({ovf, udf}), 32'd0);

    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("udf_set", 32'(udf), 32'd1);
    check("udf_count", 32'(count), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("udf_set_wins", 32'(udf), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("udf_cleared", 32'(udf), 32'd0);

    for (int i = 0; i < 3; i++) drive(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(rqempty), 32'd1);
    check("flush_ovf", 32'(ovf), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      int pw, pr;
      pw = ((i / 150) % 2 == 0) ? 75 : 30;
      pr = 100 - pw;
      wen     = ($urandom_range(99) < pw);
      wdata   = DW'($urandom);
      rnext   = ($urandom_range(99) < pr);
      flush   = ($urandom_range(99) < 2);
      err_clr = ($urandom_range(99) < 4);
      @(negedge clk);
    end
    wen = 1'b0; rnext = 1'b0; flush = 1'b0; err_clr = 1'b0;

    for (int i = 0; i < 5; i++) drive(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    wen = 1'b1; rnext = 1'b1; wdata = 8'hC7;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_rqempty", 32'(rqempty), 32'd1);
    check("arst_wqfull", 32'(wqfull), 32'd0);
    check("arst_flags", 32'({walmost_full, ralmost_empty, ovf, udf}), 32'b0100);
    @(negedge clk);
    rst = 1'b0;
    wen = 1'b1; rnext = 1'b0; wdata = 8'hA5;
    @(negedge clk);
    wen = 1'b0;
    check("post_rst_rdata", 32'(rdata), 32'hA5);
    check("post_rst_count", 32'(count), 32'd1);
    @(negedge clk);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sfifo_param.md
Name: sfifo_param

Overview:
- Parametrised single-clock FIFO, the next generation of the team's 4-entry async FIFO.
- Generalised data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Used as the buffer between AXI channel logic and the MIG user interface wherever both sides share one clock.
- First-word-fall-through read side: head data is presented on rdata whenever rqempty=0.

Parameters:
- AFIFODW, 32, data width in bits.
- AFIFOAW, 2, log2 of depth; depth = 2^AFIFOAW; legal range 1..8.
- AFULL_TH, 3, walmost_full asserts when count >= AFULL_TH; legal range 1..depth.
- AEMPTY_TH, 1, ralmost_empty asserts when count <= AEMPTY_TH; legal range 0..depth-1.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO contents.
- wen  input  1  write request.
- wdata  input  AFIFODW  write data.
- wqfull  output  1  FIFO full; writes are dropped.
- walmost_full  output  1  count >= AFULL_TH.
- rnext  input  1  pop request; consumes the current rdata.
- rdata  output  AFIFODW  head-of-queue data, valid when rqempty=0.
- rqempty  output  1  FIFO empty.
- ralmost_empty  output  1  count <= AEMPTY_TH.
- count  output  AFIFOAW+1  number of stored entries, 0..depth.
- ovf  output  1  sticky: a write was attempted while full.
- udf  output  1  sticky: a pop was attempted while empty.
- err_clr  input  1  clears ovf and udf.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: wptr=0, rptr=0, count=0, rqempty=1, wqfull=0, walmost_full=(AFULL_TH==0 ? 1 : 0), ralmost_empty=1, ovf=0, udf=0. Storage array is not reset.
- Reset may assert mid-operation; all state is discarded immediately, and the first wen after deassert writes entry 0.
- Pointers: wptr and rptr are AFIFOAW+1 bits and wrap modulo 2^(AFIFOAW+1). Array index is the low AFIFOAW bits.
- Full: pointer MSBs differ and low bits are equal. Empty: pointers are equal. count = wptr - rptr, computed at AFIFOAW+1 bits.
- All status outputs (wqfull, rqempty, almost flags, count) are registered.
  - They update on the clk edge after the triggering event.
  - They are never combinationally dependent on wen/rnext.
- Write accepted iff wen=1 and wqfull=0 and flush=0:
  - mem[wptr] <= wdata; wptr increments.
- Pop accepted iff rnext=1 and rqempty=0 and flush=0:
  - rptr increments.
- rdata = mem[rptr[AFIFOAW-1:0]], combinational read of the register array.
  - Valid only while rqempty=0; its value while empty is don't-care.
- Latency:
  - Write into an empty FIFO: rqempty deasserts, and rdata shows the written word, on the next clk edge (1 cycle).
  - Pop from a full FIFO: wqfull deasserts on the next edge.
- Simultaneous wen and rnext:
  - Not full and not empty: both accepted, count unchanged.
  - When full: only the pop is accepted; the write is dropped and ovf sets.
  - When empty: only the write is accepted; udf sets.
- Write while full: data discarded, state unchanged, ovf <= 1.
- Pop while empty: state unchanged, udf <= 1.
- flush=1: wptr <= 0, rptr <= 0, count <= 0, rqempty <= 1, wqfull <= 0.
  - Overrides any wen/rnext in the same cycle; those requests are not flagged as errors.
  - ovf/udf are unaffected.
- err_clr=1 clears ovf and udf.
  - Simultaneous new error and err_clr: the flag ends set (set wins).
- Count transitions: +1 on write-only, -1 on pop-only, 0 on both or neither. Never exceeds depth and never underflows.

Test Plan:
- Reset then idle (AFIFODW=8, AFIFOAW=2) -> rqempty=1, wqfull=0, count=0, ralmost_empty=1, ovf=udf=0.
- Write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; walmost_full=1 at count 3; wqfull=1 after the 4th write. Then 4 pops -> rdata reads 0x11..0x44 in order; rqempty=1 after the last pop.
- FIFO full; wen=1 and rnext=1 with wdata=0x55 -> pop accepted, write dropped, count=3, ovf=1. Next wen with 0x66 accepted; later drain yields 0x22,0x33,0x44,0x66.
- 10 write/pop pairs to wrap both pointers (2^3 wrap) with streaming data 0x00..0x09 -> count stays 1 in steady state; data order preserved; no ovf/udf.
- Empty FIFO, rnext=1 -> udf=1, count=0. Then err_clr=1 together with another rnext -> udf remains 1. Next err_clr alone -> udf=0.
- Count=3 with flush=1 and wen=1 in the same cycle -> next cycle count=0, rqempty=1, no ovf. Assert rst asynchronously mid-burst -> all outputs return to reset values before the next clk edge.
